// File: rtl/system1_nios2_gen2_0_cpu_debug_host_seq.sv
// Virtual-JTAG initiator for the Nios II debug slave: one IR + DR scan per command handshake.
// Optional feature macro: DEBUG_HOST_IR_CACHE_EN (skip UIR when the IR matches the last one issued).
module system1_nios2_gen2_0_cpu_debug_host_seq #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BW = $clog2(SR_WIDTH + 1);
  localparam int HW = $clog2(TCK_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UIR  = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_UDR  = 3'd4,
    S_RTI  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t              state_r, state_nx_s;
  logic [HW-1:0]       hcnt_r, hcnt_nx_s;
  logic                phase_r, phase_nx_s;
  logic [BW-1:0]       bcnt_r, bcnt_nx_s;
  logic [SR_WIDTH-1:0] data_r, shift_r, rsp_data_r;
  logic [IR_WIDTH-1:0] ir_in_r;
  logic                cmd_ready_r, cmd_ready_nx_s;
  logic                rsp_valid_r, rsp_valid_nx_s;
  logic                tck_r, tdi_r, tdi_nx_s;
  logic                uir_r, cdr_r, sdr_r, udr_r, rti_r;
  logic                active_s, half_end_s, period_end_s, last_bit_s;
  logic                accept_s, sample_s, hit_s;
  logic                unused_ir_out_s;

  // Slave IR status is not consulted by this initiator.
  assign unused_ir_out_s = ^vji_ir_out;

  assign active_s     = (state_r == S_UIR) | (state_r == S_CDR) | (state_r == S_SDR) |
                        (state_r == S_UDR) | (state_r == S_RTI);
  assign half_end_s   = (hcnt_r == HW'(TCK_DIV - 1));
  assign period_end_s = active_s & phase_r & half_end_s;
  assign last_bit_s   = (bcnt_r == BW'(SR_WIDTH - 1));
  assign accept_s     = (state_r == S_IDLE) & cmd_valid & cmd_ready_r;
  assign sample_s     = (state_r == S_SDR) & ~phase_r & half_end_s;

`ifdef DEBUG_HOST_IR_CACHE_EN
  logic cache_vld_r;
  // vji_ir_in doubles as the cached IR; the valid bit says it was actually issued.
  assign hit_s = cache_vld_r & (cmd_ir == ir_in_r);

  // IR cache valid bit: set once any command has been accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_vld_r <= 1'b0;
    end else if (accept_s) begin
      cache_vld_r <= 1'b1;
    end
  end
`else
  assign hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: every scan state ends on a whole tck period boundary.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE:  if (accept_s) state_nx_s = hit_s ? S_CDR : S_UIR; else state_nx_s = S_IDLE;
      S_UIR:   if (period_end_s) state_nx_s = S_CDR; else state_nx_s = S_UIR;
      S_CDR:   if (period_end_s) state_nx_s = S_SDR; else state_nx_s = S_CDR;
      S_SDR:   if (period_end_s && last_bit_s) state_nx_s = S_UDR; else state_nx_s = S_SDR;
      S_UDR:   if (period_end_s) state_nx_s = S_RTI; else state_nx_s = S_UDR;
      S_RTI:   if (period_end_s) state_nx_s = S_DONE; else state_nx_s = S_RTI;
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Half-period and bit counters; both fall back to zero outside the scan states.
  always_comb begin
    hcnt_nx_s  = {HW{1'b0}};
    phase_nx_s = 1'b0;
    bcnt_nx_s  = {BW{1'b0}};
    if (active_s) begin
      if (half_end_s) begin
        hcnt_nx_s  = {HW{1'b0}};
        phase_nx_s = ~phase_r;
      end else begin
        hcnt_nx_s  = hcnt_r + HW'(1'b1);
        phase_nx_s = phase_r;
      end
      if (state_r == S_SDR && period_end_s) begin
        bcnt_nx_s = last_bit_s ? {BW{1'b0}} : bcnt_r + BW'(1'b1);
      end else if (state_r == S_SDR) begin
        bcnt_nx_s = bcnt_r;
      end else begin
        bcnt_nx_s = {BW{1'b0}};
      end
    end else begin
      hcnt_nx_s  = {HW{1'b0}};
      phase_nx_s = 1'b0;
      bcnt_nx_s  = {BW{1'b0}};
    end
  end

  // Output decode: next values for the registered outputs.
  always_comb begin
    tdi_nx_s       = 1'b0;
    rsp_valid_nx_s = rsp_valid_r;
    if (state_nx_s == S_SDR) begin
      tdi_nx_s = data_r[bcnt_nx_s];
    end else begin
      tdi_nx_s = 1'b0;
    end
    if (state_r == S_DONE) begin
      rsp_valid_nx_s = 1'b1;
    end else if (rsp_valid_r && rsp_ready) begin
      rsp_valid_nx_s = 1'b0;
    end else begin
      rsp_valid_nx_s = rsp_valid_r;
    end
    cmd_ready_nx_s = (state_nx_s == S_IDLE) & ~rsp_valid_nx_s;
  end

  // Counters and command/response datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_r     <= {HW{1'b0}};
      phase_r    <= 1'b0;
      bcnt_r     <= {BW{1'b0}};
      data_r     <= {SR_WIDTH{1'b0}};
      shift_r    <= {SR_WIDTH{1'b0}};
      rsp_data_r <= {SR_WIDTH{1'b0}};
      ir_in_r    <= {IR_WIDTH{1'b0}};
    end else begin
      hcnt_r  <= hcnt_nx_s;
      phase_r <= phase_nx_s;
      bcnt_r  <= bcnt_nx_s;
      if (accept_s) begin
        data_r  <= cmd_data;
        shift_r <= {SR_WIDTH{1'b0}};
        if (!hit_s) begin
          ir_in_r <= cmd_ir;
        end
      end else if (sample_s) begin
        // tdo is taken on the clk where tck rises; bits enter at the top and move down.
        shift_r <= {vji_tdo, shift_r[SR_WIDTH-1:1]};
      end
      if (state_r == S_DONE) begin
        rsp_data_r <= shift_r;
      end
    end
  end

  // Registered interface outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      tck_r       <= 1'b0;
      tdi_r       <= 1'b0;
      uir_r       <= 1'b0;
      cdr_r       <= 1'b0;
      sdr_r       <= 1'b0;
      udr_r       <= 1'b0;
      rti_r       <= 1'b0;
    end else begin
      cmd_ready_r <= cmd_ready_nx_s;
      rsp_valid_r <= rsp_valid_nx_s;
      tck_r       <= phase_nx_s;
      tdi_r       <= tdi_nx_s;
      uir_r       <= (state_nx_s == S_UIR);
      cdr_r       <= (state_nx_s == S_CDR);
      sdr_r       <= (state_nx_s == S_SDR);
      udr_r       <= (state_nx_s == S_UDR);
      rti_r       <= (state_nx_s == S_RTI);
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign vji_tck   = tck_r;
  assign vji_tdi   = tdi_r;
  assign vji_ir_in = ir_in_r;
  assign vji_uir   = uir_r;
  assign vji_cdr   = cdr_r;
  assign vji_sdr   = sdr_r;
  assign vji_udr   = udr_r;
  assign vji_rti   = rti_r;

endmodule
